fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Forwarding and load-use hazard unit for the core_lapido pipeline. It tracks the destination register address picked by the register-destination select in ID as that address moves through EX, MEM and WB. From that state it generates the 2-bit selects for the two 5-input-address-driven 3:1 operand multiplexers in EX, encoded 00/01/10. It also raises a one-cycle stall on load-use dependencies and inserts the matching bubble.

## Interface
Parameters:
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pipe_en`  in  1  global pipeline advance. When low, all internal state and outputs hold.
- `flush`  in  1  turns the ID instruction entering EX into a bubble.
- `id_rs`  in  AW  source A address of the instruction in ID.
- `id_rt`  in  AW  source B address of the instruction in ID.
- `id_dst`  in  AW  destination address of the instruction in ID, taken from the register-destination mux output.
- `id_reg_write`  in  1  ID instruction writes `id_dst`.
- `id_mem_read`  in  1  ID instruction is a load.
- `fwd_a_sel`  out  2  EX operand A select. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- `fwd_b_sel`  out  2  EX operand B select, same encoding.
- `stall`  out  1  load-use stall request. Combinational. Holds PC and IF/ID; ID/EX receives a bubble.

## Operation
- Internal stage records: EX, MEM and WB, each holding {dst[AW-1:0], wr, ld}.
- A record is "writing" when wr=1 and dst≠0. Register 0 is never forwarded and never causes a stall.
- stall = EX.ld & EX.writing & ((EX.dst==id_rs) | (EX.dst==id_rt)).
  - stall is evaluated regardless of `pipe_en`.
- On each edge with pipe_en=1:
  - WB←MEM and MEM←EX.
  - EX←{id_dst, id_reg_write, id_mem_read}, unless stall=1 or flush=1. In that case EX←bubble {0,0,0}.
- Next `fwd_a_sel`, computed from the current state and registered at the same edge:
  - 01 if the current EX record is writing and EX.dst==id_rs.
  - Otherwise 10 if the current MEM record is writing and MEM.dst==id_rs.
  - Otherwise 00.
- `fwd_b_sel` is computed the same way using id_rt.
- When a bubble is inserted (stall or flush), both selects load 00.
- Priority: EX/MEM (newer result) beats MEM/WB on a double match.
- Code 11 is never produced.
- With pipe_en=0, flush is ignored and nothing changes.
- A WB-stage write to the same address read in ID is resolved by the register file write-before-read. It is out of scope here.

## Timing
- Reset (async, rst_n=0):
  - All stage records become {0,0,0}.
  - fwd_a_sel = fwd_b_sel = 00.
  - stall = 0, since the EX record is cleared.
- Forwarding selects are registered. They are valid for the whole cycle the consuming instruction spends in EX, one edge after it was in ID.
- stall asserts in the same cycle the dependent instruction sits in ID, and lasts exactly one cycle per load-use pair.
  - After the bubble, the load is in MEM.
  - The dependent instruction then enters EX with select 10.
- Reset asserted mid-stall: stall drops immediately and the bubble is discarded. After release, the first instruction sees selects 00.
- Simultaneous stall and flush: a single bubble. Behaviour is identical to either one alone.

## Structure
- Shared package `lapido_pkg`:
  - Constants `FWD_REG=2'b00`, `FWD_EXMEM=2'b01`, `FWD_MEMWB=2'b10`.
  - Register address width `REG_AW=5`.
  - The stage-record struct {dst, wr, ld}.
- One sub-module, `fwd_sel_gen`: combinational. Takes one source address plus the EX and MEM records and returns a 2-bit select. It is instantiated twice, for A and B.
- Stage registers and stall logic live in the top.

## Test plan
- Reset: drive rst_n=0 with random inputs -> fwd_a_sel=00, fwd_b_sel=00, stall=0. Release and check one idle cycle -> all outputs stay 0.
- Distance 1: ID dst=5, wr=1; next cycle ID rs=5 -> after the edge fwd_a_sel=01. Distance 2 with rt=5 -> fwd_b_sel=10.
- Double match: two consecutive writers to r9, then rs=9 -> fwd_a_sel=01 (newest wins).
- Load-use: load dst=8, then rt=8 -> stall=1 for exactly one cycle, the EX record becomes a bubble, then fwd_b_sel=10.
- Register zero: writer with dst=0, then rs=0 and rt=0 -> both selects 00, stall=0, including a load to r0.
- Control: with pipe_en=0 for 3 cycles, selects hold their values. flush with a matching writer in ID -> the next consumer gets 00. rst_n pulse during a stall -> stall=0 asynchronously.

Source files
------------

// File: rtl/lapido_pkg.sv
// Shared definitions for the core_lapido pipeline hazard logic.
//   REG_AW       register address width
//   FWD_*        EX operand mux select codes
//   stage_rec_t  per-stage destination record {dst, wr, ld}
package lapido_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
  } stage_rec_t;

  // A record only matters to forwarding if it writes a register other than r0.
  function automatic logic rec_writing(input stage_rec_t rec);
    return rec.wr && (rec.dst != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Combinational forwarding select for one EX operand.
//   i_src  source register address of the instruction in ID
//   i_ex   record of the instruction currently in EX
//   i_mem  record of the instruction currently in MEM
//   o_sel  select the operand will use once it reaches EX
module fwd_sel_gen
  import lapido_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  stage_rec_t        i_ex,
  input  stage_rec_t        i_mem,
  output logic [1:0]        o_sel
);

  // Load flags do not affect the select: a load in EX that matches stalls
  // and bubbles, and a load in MEM forwards from MEM/WB like any writer.
  logic w_unused_ld;
  assign w_unused_ld = i_ex.ld ^ i_mem.ld;

  // The EX instruction is newer than MEM, so it wins a double match.
  always_comb begin
    o_sel = FWD_REG;
    if (rec_writing(i_ex) && (i_ex.dst == i_src)) begin
      o_sel = FWD_EXMEM;
    end else if (rec_writing(i_mem) && (i_mem.dst == i_src)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for core_lapido.
// Tracks destination records through EX/MEM/WB and produces registered
// EX operand selects plus a combinational load-use stall.
//   clk, rst_n        clock, async active-low reset
//   pipe_en           pipeline advance; low holds all state
//   flush             turn the ID instruction entering EX into a bubble
//   id_rs, id_rt      source addresses in ID
//   id_dst            destination address in ID
//   id_reg_write      ID instruction writes id_dst
//   id_mem_read       ID instruction is a load
//   fwd_a_sel/b_sel   registered EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall             load-use stall (holds PC and IF/ID)
module fwd_hazard_unit
  import lapido_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_en,
  input  logic          flush,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          stall
);

  stage_rec_t r_ex;
  stage_rec_t r_mem;
  stage_rec_t r_wb;
  logic [1:0] r_a_sel;
  logic [1:0] r_b_sel;

  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;
  logic       w_bubble;
  logic       w_unused_wb;

  // The WB write is resolved by the register file's write-before-read, so
  // the WB record has no consumer here; it is kept to complete the history.
  assign w_unused_wb = ^r_wb;

  // Stall depends only on the EX record and the ID sources, so it is live
  // even while pipe_en is low.
  assign stall = r_ex.ld && rec_writing(r_ex) &&
                 ((r_ex.dst == id_rs) || (r_ex.dst == id_rt));

  assign w_bubble = stall || flush;

  fwd_sel_gen u_sel_a (
    .i_src (id_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_a_sel)
  );

  fwd_sel_gen u_sel_b (
    .i_src (id_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_b_sel)
  );

  // ID -> EX -> MEM -> WB record shift; selects land with the instruction in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_a_sel <= FWD_REG;
      r_b_sel <= FWD_REG;
    end else if (pipe_en) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_bubble) begin
        r_ex    <= '0;
        r_a_sel <= FWD_REG;
        r_b_sel <= FWD_REG;
      end else begin
        r_ex    <= '{dst: id_dst, wr: id_reg_write, ld: id_mem_read};
        r_a_sel <= w_a_sel;
        r_b_sel <= w_b_sel;
      end
    end
  end

  assign fwd_a_sel = r_a_sel;
  assign fwd_b_sel = r_b_sel;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_en;
  logic       flush;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_reg_write, id_mem_read;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_en      (pipe_en),
    .flush        (flush),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit pe; bit fl;
    int rs; int rt; int dst;
    bit wr; bit ld;
    bit est; int ea; int eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit pe, bit fl, int rs, int rt, int dst,
                              bit wr, bit ld, bit est, int ea, int eb);
    vec_t v;
    v.pe = pe; v.fl = fl; v.rs = rs; v.rt = rt; v.dst = dst;
    v.wr = wr; v.ld = ld; v.est = est; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input bit pe, input bit fl, input int rs, input int rt,
                       input int dst, input bit wr, input bit ld);
    pipe_en = pe; flush = fl;
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_dst = dst[4:0];
    id_reg_write = wr; id_mem_read = ld;
  endtask

  // Reference model: history of instructions that entered EX, newest first.
  typedef struct { int dst; bit wr; bit ld; } mrec_t;
  mrec_t hist[$];
  int m_a, m_b;

  function automatic bit m_writes(mrec_t r, int addr);
    return r.wr && r.dst != 0 && r.dst == addr;
  endfunction

  function automatic void m_reset();
    mrec_t z;
    z.dst = 0; z.wr = 0; z.ld = 0;
    hist = {z, z, z};
    m_a = 0; m_b = 0;
  endfunction

  function automatic bit m_stall(int rs, int rt);
    return hist[0].ld && (m_writes(hist[0], rs) || m_writes(hist[0], rt));
  endfunction

  function automatic int m_src(int src);
    if (m_writes(hist[0], src)) return 1;
    if (m_writes(hist[1], src)) return 2;
    return 0;
  endfunction

  function automatic void m_edge(bit pe, bit fl, int rs, int rt, int dst, bit wr, bit ld);
    mrec_t n;
    bit bub;
    if (!pe) return;
    bub = m_stall(rs, rt) || fl;
    n.dst = bub ? 0 : dst; n.wr = bub ? 0 : wr; n.ld = bub ? 0 : ld;
    m_a = bub ? 0 : m_src(rs);
    m_b = bub ? 0 : m_src(rt);
    hist.push_front(n);
    void'(hist.pop_back());
  endfunction

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", fwd_a_sel, 0);
    check("rst_b", fwd_b_sel, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("idle_a", fwd_a_sel, 0);
    check("idle_b", fwd_b_sel, 0);
    check("idle_stall", stall, 0);

    // Directed table: pe fl rs rt dst wr ld | stall(pre-edge) a b (post-edge)
    vecs.push_back(mk(1, 0, 1,  2,  5,  1, 0, 0, 0, 0));  // writer r5
    vecs.push_back(mk(1, 0, 5,  3,  6,  0, 0, 0, 1, 0));  // dist 1 on A
    vecs.push_back(mk(1, 0, 7,  5,  0,  0, 0, 0, 0, 2));  // dist 2 on B
    vecs.push_back(mk(1, 0, 0,  0,  9,  1, 0, 0, 0, 0));  // writer r9
    vecs.push_back(mk(1, 0, 1,  2,  9,  1, 0, 0, 0, 0));  // writer r9 again
    vecs.push_back(mk(1, 0, 9,  9,  0,  0, 0, 0, 1, 1));  // newest wins
    vecs.push_back(mk(1, 0, 0,  0,  8,  1, 1, 0, 0, 0));  // load r8
    vecs.push_back(mk(1, 0, 1,  8, 10,  1, 0, 1, 0, 0));  // load-use: stall+bubble
    vecs.push_back(mk(1, 0, 1,  8, 10,  1, 0, 0, 0, 2));  // replay -> MEM/WB
    vecs.push_back(mk(1, 0, 0,  0,  0,  1, 1, 0, 0, 0));  // load to r0
    vecs.push_back(mk(1, 0, 0,  0,  0,  1, 0, 0, 0, 0));  // r0 consumer
    vecs.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 12,  1, 0, 0, 0, 0));  // writer r12
    vecs.push_back(mk(1, 0, 12, 12, 0,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0,  0,  3,  1, 0, 0, 1, 1));  // hold x3, flush ignored
    vecs.push_back(mk(0, 1, 0,  0,  3,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0,  0,  3,  1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0,  12, 0,  0, 0, 0, 0, 2));  // state survived hold
    vecs.push_back(mk(1, 1, 0,  0, 14,  1, 0, 0, 0, 0));  // flushed writer r14
    vecs.push_back(mk(1, 0, 14, 14, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  0, 20,  1, 1, 0, 0, 0));  // load r20
    vecs.push_back(mk(0, 0, 20, 0,  0,  0, 0, 1, 0, 0));  // stall while frozen
    vecs.push_back(mk(1, 1, 20, 0,  0,  0, 0, 1, 0, 0));  // stall + flush: one bubble
    vecs.push_back(mk(1, 0, 20, 0,  0,  0, 0, 0, 2, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pe, vecs[i].fl, vecs[i].rs, vecs[i].rt, vecs[i].dst,
            vecs[i].wr, vecs[i].ld);
      #1;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].est);
      @(posedge clk); #1;
      check($sformatf("vec%0d_a", i), fwd_a_sel, vecs[i].ea);
      check($sformatf("vec%0d_b", i), fwd_b_sel, vecs[i].eb);
    end

    // Reset pulse during a stall
    @(negedge clk);
    drive(1, 0, 0, 0, 7, 1, 1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 7, 0, 0, 0, 0);
    #1;
    check("rststall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    check("rststall_async", stall, 0);
    check("rststall_a", fwd_a_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 7, 7, 0, 0, 0);
    #1;
    check("rststall_after", stall, 0);
    @(posedge clk); #1;
    check("rststall_first_a", fwd_a_sel, 0);
    check("rststall_first_b", fwd_b_sel, 0);

    // Randomized run against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 500; c++) begin
      bit pe, fl, wr, ld;
      int rs, rt, dst;
      @(negedge clk);
      pe  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      rs  = $urandom_range(0, 3);
      rt  = $urandom_range(0, 3);
      dst = $urandom_range(0, 3);
      wr  = $urandom_range(0, 1);
      ld  = wr && ($urandom_range(0, 2) == 0);
      drive(pe, fl, rs, rt, dst, wr, ld);
      #1;
      check($sformatf("rnd%0d_stall", c), stall, m_stall(rs, rt));
      m_edge(pe, fl, rs, rt, dst, wr, ld);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_a", c), fwd_a_sel, m_a);
      check($sformatf("rnd%0d_b", c), fwd_b_sel, m_b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
